// File: rtl/wbufifo.sv
// wbufifo: synchronous FIFO of 2^LGFLEN words; a write while full is dropped (o_err pulses)
// unless a read frees a slot in the same cycle.
module wbufifo #(
    parameter int BW = 8,
    parameter int LGFLEN = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [BW-1:0] i_data,
    input  logic          i_rd,
    output logic [BW-1:0] o_data,
    output logic          o_empty_n,
    output logic          o_full,
    output logic          o_err
);
    logic [BW-1:0] mem_q [0:(1<<LGFLEN)-1];
    logic [LGFLEN:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic err_q, err_d, do_wr, do_rd;
    assign o_empty_n = wr_ptr_q != rd_ptr_q;
    assign o_full = (wr_ptr_q[LGFLEN] != rd_ptr_q[LGFLEN])
                 && (wr_ptr_q[LGFLEN-1:0] == rd_ptr_q[LGFLEN-1:0]);
    assign do_rd = i_rd && o_empty_n;
    assign do_wr = i_wr && (!o_full || do_rd);
    assign o_data = mem_q[rd_ptr_q[LGFLEN-1:0]];
    assign o_err = err_q;
    always_comb begin
        wr_ptr_d = wr_ptr_q + (LGFLEN+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (LGFLEN+1)'(do_rd);
        err_d = i_wr && !do_wr;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q <= err_d;
        end
    end
    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_wr) mem_q[wr_ptr_q[LGFLEN-1:0]] <= i_data;
    end
endmodule

// File: rtl/wbu_txarb.sv
// wbu_txarb: arbitrates one UART transmitter between the bus-output byte stream and a
// console FIFO, granting whole lines per source with an idle timeout and a console byte cap.
module wbu_txarb #(
    parameter int CON_LGFIFO = 6,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CON_MAX = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bus_stb,
    input  logic [7:0] i_bus_char,
    output logic       o_bus_busy,
    input  logic       i_con_stb,
    input  logic [7:0] i_con_char,
    output logic       o_con_full,
    output logic       o_con_err,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_char,
    input  logic       i_tx_busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_CON = 2'd2;
    localparam logic [7:0] NEWLINE = 8'h0a;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int CW = $clog2(CON_MAX + 1);
    logic [1:0] state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] con_cnt_q, con_cnt_d;
    logic tx_stb_q, tx_stb_d;
    logic [7:0] tx_char_q, tx_char_d, fifo_data;
    logic load_ok, bus_acc, con_pop, fifo_ne;
    assign load_ok = !tx_stb_q || !i_tx_busy;
    assign o_bus_busy = i_rst || !(state_q == S_BUS && load_ok);
    assign bus_acc = i_bus_stb && !o_bus_busy;
    assign con_pop = !i_rst && state_q == S_CON && load_ok && fifo_ne;
    assign o_tx_stb = tx_stb_q;
    assign o_tx_char = tx_char_q;
    wbufifo #(8, CON_LGFIFO) u_fifo (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_wr(i_con_stb),
        .i_data(i_con_char),
        .i_rd(con_pop),
        .o_data(fifo_data),
        .o_empty_n(fifo_ne),
        .o_full(o_con_full),
        .o_err(o_con_err)
    );
    always_comb begin
        state_d = state_q;
        idle_cnt_d = '0;
        con_cnt_d = con_cnt_q;
        tx_stb_d = load_ok ? (bus_acc || con_pop) : tx_stb_q;
        tx_char_d = bus_acc ? i_bus_char : con_pop ? fifo_data : tx_char_q;
        if (state_q == S_IDLE) begin
            con_cnt_d = '0;
            state_d = i_bus_stb ? S_BUS : fifo_ne ? S_CON : S_IDLE;
        end else if (state_q == S_BUS) begin
            idle_cnt_d = i_bus_stb ? '0 : idle_cnt_q + 1'b1;
            if ((bus_acc && i_bus_char == NEWLINE) || idle_cnt_d == IW'(IDLE_TIMEOUT))
                state_d = S_IDLE;
        end else begin
            if (con_pop && con_cnt_q != CW'(CON_MAX)) con_cnt_d = con_cnt_q + 1'b1;
            // An empty FIFO ends the grant one cycle after its last pop.
            if ((con_pop && fifo_data == NEWLINE) || !fifo_ne
                || (con_cnt_d == CW'(CON_MAX) && i_bus_stb))
                state_d = S_IDLE;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idle_cnt_q <= '0;
            con_cnt_q <= '0;
            tx_stb_q <= 1'b0;
            tx_char_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idle_cnt_q <= idle_cnt_d;
            con_cnt_q <= con_cnt_d;
            tx_stb_q <= tx_stb_d;
            tx_char_q <= tx_char_d;
        end
    end
endmodule

// File: tb/tb_wbu_txarb.sv
// tb_wbu_txarb: directed stimulus with a queue scoreboard; the monitor compares every byte
// the transmitter takes against the expected stream.
module tb_wbu_txarb;
    logic i_clk = 1'b0, i_rst = 1'b1, i_bus_stb = 1'b0, i_con_stb = 1'b0, i_tx_busy = 1'b0;
    logic [7:0] i_bus_char = 8'h00, i_con_char = 8'h00, o_tx_char;
    logic o_bus_busy, o_con_full, o_con_err, o_tx_stb;
    int errors = 0, checks = 0, err_pulses = 0;
    logic [7:0] exp_q [$];

    always #5 i_clk = ~i_clk;

    wbu_txarb dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_bus_stb(i_bus_stb), .i_bus_char(i_bus_char), .o_bus_busy(o_bus_busy),
        .i_con_stb(i_con_stb), .i_con_char(i_con_char), .o_con_full(o_con_full),
        .o_con_err(o_con_err), .o_tx_stb(o_tx_stb), .o_tx_char(o_tx_char),
        .i_tx_busy(i_tx_busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_con_err) err_pulses++;
        if (!i_rst && o_tx_stb && !i_tx_busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got %h expected no byte", o_tx_char);
            end else check("tx_byte", o_tx_char, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic con_write(input logic [7:0] c);
        i_con_stb = 1'b1;
        i_con_char = c;
        tick();
        i_con_stb = 1'b0;
    endtask

    // Holds i_bus_stb high on return; the caller decides when to drop it.
    task automatic bus_send(input logic [7:0] c);
        logic acc;
        acc = 1'b0;
        i_bus_stb = 1'b1;
        i_bus_char = c;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge i_clk);
            acc = !o_bus_busy;
            tick();
        end
        check("bus_accept", 8'(acc), 8'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
        check(name, 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        int e0;
        tick(); tick();
        @(negedge i_clk);
        check("rst_tx_stb", 8'(o_tx_stb), 8'd0);
        check("rst_tx_char", o_tx_char, 8'h00);
        check("rst_con_full", 8'(o_con_full), 8'd0);
        check("rst_con_err", 8'(o_con_err), 8'd0);
        check("rst_bus_busy", 8'(o_bus_busy), 8'd1);
        tick();
        i_rst = 1'b0;
        tick();

        // bus-only line "A1\n" and first-byte latency
        exp_q.push_back(8'h41); exp_q.push_back(8'h31); exp_q.push_back(8'h0a);
        fork
            begin bus_send(8'h41); bus_send(8'h31); bus_send(8'h0a); end
            begin
                tick();
                @(negedge i_clk);
                check("lat_cycle1_stb", 8'(o_tx_stb), 8'd0);
                tick();
                @(negedge i_clk);
                check("lat_cycle2_stb", 8'(o_tx_stb), 8'd1);
                check("lat_cycle2_char", o_tx_char, 8'h41);
            end
        join
        @(negedge i_clk);
        check("bus_line_end_busy", 8'(o_bus_busy), 8'd1);
        i_bus_stb = 1'b0;
        wait_drain("bus_drain", 20);

        // contention: console line "hi\n" in progress, bus waits for it
        i_tx_busy = 1'b1;
        exp_q.push_back(8'h68); exp_q.push_back(8'h69); exp_q.push_back(8'h0a);
        exp_q.push_back(8'h58); exp_q.push_back(8'h0a);
        con_write(8'h68); con_write(8'h69); con_write(8'h0a);
        tick(); tick();
        i_tx_busy = 1'b0;
        bus_send(8'h58); bus_send(8'h0a);
        i_bus_stb = 1'b0;
        wait_drain("contention_drain", 30);

        // fairness: 64 console bytes then the waiting bus line, then the rest
        i_tx_busy = 1'b1;
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(8'h20 + i));
        exp_q.push_back(8'h42); exp_q.push_back(8'h0a);
        for (int i = 64; i < 100; i++) exp_q.push_back(8'(8'h20 + i));
        for (int i = 0; i < 30; i++) con_write(8'(8'h20 + i));
        fork
            begin bus_send(8'h42); bus_send(8'h0a); i_bus_stb = 1'b0; end
            begin
                i_tx_busy = 1'b0;
                for (int i = 30; i < 100; i++) con_write(8'(8'h20 + i));
            end
        join
        wait_drain("fairness_drain", 400);

        // idle timeout releases the bus grant to a waiting console byte
        exp_q.push_back(8'h5a); exp_q.push_back(8'h63);
        bus_send(8'h5a);
        i_bus_stb = 1'b0;
        con_write(8'h63);
        repeat (6) tick();
        @(negedge i_clk);
        check("timeout_hold", 8'(o_tx_stb), 8'd0);
        wait_drain("timeout_drain", 60);

        // overflow: output register stuck on a bus byte, 65 console writes
        i_tx_busy = 1'b1;
        e0 = err_pulses;
        exp_q.push_back(8'h51);
        bus_send(8'h51);
        i_bus_stb = 1'b0;
        for (int i = 0; i < 65; i++) begin
            if (i < 64) exp_q.push_back(8'(8'h80 + i));
            con_write(8'(8'h80 + i));
        end
        repeat (2) tick();
        @(negedge i_clk);
        check("ovf_full", 8'(o_con_full), 8'd1);
        check("ovf_err_pulses", 8'(err_pulses - e0), 8'd1);
        tick();
        i_tx_busy = 1'b0;
        wait_drain("ovf_drain", 300);
        check("ovf_full_after", 8'(o_con_full), 8'd0);
        repeat (25) tick();

        // reset mid-operation discards the output byte and the FIFO
        i_tx_busy = 1'b1;
        bus_send(8'h52);
        i_bus_stb = 1'b0;
        for (int i = 0; i < 5; i++) con_write(8'(8'h30 + i));
        @(negedge i_clk);
        check("pre_rst_tx_stb", 8'(o_tx_stb), 8'd1);
        tick();
        i_rst = 1'b1;
        @(negedge i_clk);
        check("in_rst_bus_busy", 8'(o_bus_busy), 8'd1);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_tx_stb", 8'(o_tx_stb), 8'd0);
        check("post_rst_tx_char", o_tx_char, 8'h00);
        tick();
        i_tx_busy = 1'b0;
        repeat (30) tick();
        @(negedge i_clk);
        check("post_rst_quiet", 8'(o_tx_stb), 8'd0);
        check("post_rst_exp_empty", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
